stn_panel_rx: RTL and testbench

- Receive-side model/monitor for the 4-bit monochrome STN panel interface (FPFRAME, FPLINE, FPSHIFT, FPDAT[3:0]); the counterpart of the panel timing source.
- Oversamples the panel pins in the clk domain and recovers nibble data with x/y coordinates.
- Checks line length and frame height, and produces a per-frame signature for regression comparison.
- Sits in the simulation/FPGA test harness between the LCDC panel pins and a frame-buffer or scoreboard.

---
 rtl/stn_panel_rx.sv | 196 +++++++++++++++++++
 tb/tb_stn_panel_rx.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stn_panel_rx.sv
// Receive-side monitor for a 4-bit monochrome STN panel interface. It recovers nibbles
// with x/y coordinates, checks line and frame geometry, and signs each frame.
module stn_panel_rx #(
  parameter int H_PIX   = 320,
  parameter int V_LINES = 240
) (
  input  logic       clk,
  input  logic       rst_x,
  input  logic       enable,
  input  logic       err_clr,
  input  logic       P_FPFRAME,
  input  logic       P_FPLINE,
  input  logic       P_FPSHIFT,
  input  logic [3:0] P_FPDAT,
  output logic       pix_vld,
  output logic [8:0] pix_x,
  output logic [7:0] pix_y,
  output logic [3:0] pix_dat,
  output logic       frame_done,
  output logic [15:0] frame_sum,
  output logic [8:0] frame_lines,
  output logic       err_hlen,
  output logic       err_vlen
);

  localparam logic [6:0] SHIFTS_PER_LINE = 7'(H_PIX / 4);
  localparam logic [8:0] LINES_PER_FRAME = 9'(V_LINES);
  localparam logic [6:0] SCNT_MAX        = 7'd127;
  localparam logic [8:0] LCNT_MAX        = 9'd511;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

  // Pin bundle {frame, line, shift, dat[3:0]}; all bits share the same pipeline so DAT stays aligned.
  logic [6:0] sync1_r, sync2_r, sync3_r;

  state_t     state_r, state_s;
  logic [6:0] scnt_r, scnt_s, scnt_a_s;
  logic [8:0] lcnt_r, lcnt_s, lcnt_b_s;
  logic [15:0] sum_r, sum_s, sum_a_s;

  logic       pix_vld_s;
  logic [8:0] pix_x_s;
  logic [7:0] pix_y_s;
  logic [3:0] pix_dat_s;
  logic       frame_done_s;
  logic [15:0] frame_sum_s;
  logic [8:0] frame_lines_s;
  logic       hlen_set_s, vlen_set_s;
  logic       close_line_s;

  logic       fr_rise_s, ln_rise_s, sh_fall_s;
  logic [3:0] dat_s;

  assign fr_rise_s = sync2_r[6] & ~sync3_r[6];
  assign ln_rise_s = sync2_r[5] & ~sync3_r[5];
  assign sh_fall_s = ~sync2_r[4] & sync3_r[4];
  assign dat_s     = sync3_r[3:0];

  // Pin synchronizer and edge-delay stages.
  always_ff @(posedge clk or negedge rst_x) begin
    if (!rst_x) begin
      sync1_r <= 7'd0;
      sync2_r <= 7'd0;
      sync3_r <= 7'd0;
    end else begin
      sync1_r <= {P_FPFRAME, P_FPLINE, P_FPSHIFT, P_FPDAT};
      sync2_r <= sync1_r;
      sync3_r <= sync2_r;
    end
  end

  // Next state, counters and outputs; shift, line and frame events are applied in that order.
  always_comb begin
    state_s       = state_r;
    scnt_s        = scnt_r;
    lcnt_s        = lcnt_r;
    sum_s         = sum_r;
    scnt_a_s      = scnt_r;
    sum_a_s       = sum_r;
    lcnt_b_s      = lcnt_r;
    close_line_s  = 1'b0;
    pix_vld_s     = 1'b0;
    pix_x_s       = pix_x;
    pix_y_s       = pix_y;
    pix_dat_s     = pix_dat;
    frame_done_s  = 1'b0;
    frame_sum_s   = frame_sum;
    frame_lines_s = frame_lines;
    hlen_set_s    = 1'b0;
    vlen_set_s    = 1'b0;

    if (!enable) begin
      state_s = IDLE;
      scnt_s  = 7'd0;
      lcnt_s  = 9'd0;
      sum_s   = 16'd0;
    end else begin
      case (state_r)
        IDLE: begin
          if (fr_rise_s) begin
            state_s = ACTIVE;
            scnt_s  = 7'd0;
            lcnt_s  = 9'd0;
            sum_s   = 16'd0;
          end else begin
            state_s = IDLE;
          end
        end
        ACTIVE: begin
          if (sh_fall_s) begin
            if ((scnt_r < SHIFTS_PER_LINE) && (lcnt_r < LINES_PER_FRAME)) begin
              pix_vld_s = 1'b1;
              pix_x_s   = {scnt_r, 2'b00};
              pix_y_s   = lcnt_r[7:0];
              pix_dat_s = dat_s;
              sum_a_s   = {sum_r[14:0], sum_r[15]} ^ {12'h000, dat_s};
            end else begin
              sum_a_s   = sum_r;
            end
            scnt_a_s = (scnt_r == SCNT_MAX) ? scnt_r : scnt_r + 7'd1;
          end else begin
            scnt_a_s = scnt_r;
          end

          // A frame pulse also closes a line that still has shifts pending.
          close_line_s = (ln_rise_s || fr_rise_s) && (scnt_a_s != 7'd0);
          if (close_line_s) begin
            hlen_set_s = (scnt_a_s != SHIFTS_PER_LINE);
            lcnt_b_s   = (lcnt_r == LCNT_MAX) ? lcnt_r : lcnt_r + 9'd1;
            scnt_s     = 7'd0;
          end else begin
            lcnt_b_s   = lcnt_r;
            scnt_s     = scnt_a_s;
          end
          lcnt_s = lcnt_b_s;
          sum_s  = sum_a_s;

          if (fr_rise_s) begin
            frame_done_s  = 1'b1;
            frame_sum_s   = sum_a_s;
            frame_lines_s = lcnt_b_s;
            vlen_set_s    = (lcnt_b_s != LINES_PER_FRAME);
            scnt_s        = 7'd0;
            lcnt_s        = 9'd0;
            sum_s         = 16'd0;
          end else begin
            frame_done_s  = 1'b0;
          end
        end
        default: begin
          state_s = IDLE;
          scnt_s  = 7'd0;
          lcnt_s  = 9'd0;
          sum_s   = 16'd0;
        end
      endcase
    end
  end

  // State, counter and registered-output update; a flag set in the same cycle as err_clr wins.
  always_ff @(posedge clk or negedge rst_x) begin
    if (!rst_x) begin
      state_r     <= IDLE;
      scnt_r      <= 7'd0;
      lcnt_r      <= 9'd0;
      sum_r       <= 16'd0;
      pix_vld     <= 1'b0;
      pix_x       <= 9'd0;
      pix_y       <= 8'd0;
      pix_dat     <= 4'd0;
      frame_done  <= 1'b0;
      frame_sum   <= 16'd0;
      frame_lines <= 9'd0;
      err_hlen    <= 1'b0;
      err_vlen    <= 1'b0;
    end else begin
      state_r     <= state_s;
      scnt_r      <= scnt_s;
      lcnt_r      <= lcnt_s;
      sum_r       <= sum_s;
      pix_vld     <= pix_vld_s;
      pix_x       <= pix_x_s;
      pix_y       <= pix_y_s;
      pix_dat     <= pix_dat_s;
      frame_done  <= frame_done_s;
      frame_sum   <= frame_sum_s;
      frame_lines <= frame_lines_s;
      err_hlen    <= (err_hlen & ~err_clr) | hlen_set_s;
      err_vlen    <= (err_vlen & ~err_clr) | vlen_set_s;
    end
  end

endmodule

// File: tb/tb_stn_panel_rx.sv
// Directed bench for stn_panel_rx: a transaction-level panel model predicts pixels and
// frame results, and a compare process checks every pix_vld and frame_done against it.
`timescale 1ns/1ps
module tb_stn_panel_rx;

  localparam int H_PIX   = 320;
  localparam int V_LINES = 8;
  localparam int HS      = H_PIX / 4;

  logic        clk = 1'b0;
  logic        rst_x = 1'b0;
  logic        enable = 1'b0;
  logic        err_clr = 1'b0;
  logic        P_FPFRAME = 1'b0;
  logic        P_FPLINE = 1'b0;
  logic        P_FPSHIFT = 1'b0;
  logic [3:0]  P_FPDAT = 4'd0;
  logic        pix_vld;
  logic [8:0]  pix_x;
  logic [7:0]  pix_y;
  logic [3:0]  pix_dat;
  logic        frame_done;
  logic [15:0] frame_sum;
  logic [8:0]  frame_lines;
  logic        err_hlen;
  logic        err_vlen;

  stn_panel_rx #(.H_PIX(H_PIX), .V_LINES(V_LINES)) dut (
    .clk(clk), .rst_x(rst_x), .enable(enable), .err_clr(err_clr),
    .P_FPFRAME(P_FPFRAME), .P_FPLINE(P_FPLINE), .P_FPSHIFT(P_FPSHIFT), .P_FPDAT(P_FPDAT),
    .pix_vld(pix_vld), .pix_x(pix_x), .pix_y(pix_y), .pix_dat(pix_dat),
    .frame_done(frame_done), .frame_sum(frame_sum), .frame_lines(frame_lines),
    .err_hlen(err_hlen), .err_vlen(err_vlen)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [8:0] x;
    logic [7:0] y;
    logic [3:0] d;
  } pix_t;

  typedef struct packed {
    logic [15:0] sum;
    logic [8:0]  lines;
  } frm_t;

  pix_t pq[$];
  frm_t fq[$];

  int vectors = 0;
  int miscompares = 0;

  // Panel-level model of the receiver
  bit          m_en = 1'b0;
  bit          m_active = 1'b0;
  int          m_scnt = 0;
  int          m_lcnt = 0;
  logic [15:0] m_sum = 16'd0;
  bit          m_hlen = 1'b0;
  bit          m_vlen = 1'b0;

  bit          f_seen = 1'b0;
  logic [8:0]  f_x = 9'd0;
  logic [7:0]  f_y = 8'd0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic m_clear();
    m_scnt = 0;
    m_lcnt = 0;
    m_sum  = 16'd0;
  endtask

  task automatic m_close_line();
    if (m_scnt != 0) begin
      if (m_scnt != HS) m_hlen = 1'b1;
      if (m_lcnt < 511) m_lcnt++;
      m_scnt = 0;
    end
  endtask

  task automatic do_shift(input logic [3:0] d);
    pix_t p;
    if (m_active) begin
      if (m_scnt < HS && m_lcnt < V_LINES) begin
        p.x = 9'(m_scnt * 4);
        p.y = 8'(m_lcnt);
        p.d = d;
        pq.push_back(p);
        m_sum = {m_sum[14:0], m_sum[15]} ^ {12'h000, d};
      end
      if (m_scnt < 127) m_scnt++;
    end
    P_FPDAT = d;
    P_FPSHIFT = 1'b1;
    tick(2);
    P_FPSHIFT = 1'b0;
    tick(2);
  endtask

  task automatic do_line();
    if (m_active) m_close_line();
    P_FPLINE = 1'b1;
    tick(2);
    P_FPLINE = 1'b0;
    tick(2);
  endtask

  task automatic do_frame();
    frm_t f;
    if (m_active) begin
      m_close_line();
      f.sum = m_sum;
      f.lines = 9'(m_lcnt);
      fq.push_back(f);
      if (m_lcnt != V_LINES) m_vlen = 1'b1;
      m_clear();
    end else if (m_en) begin
      m_active = 1'b1;
      m_clear();
    end
    P_FPFRAME = 1'b1;
    tick(2);
    P_FPFRAME = 1'b0;
    tick(2);
  endtask

  task automatic do_err_clr();
    err_clr = 1'b1;
    tick(1);
    err_clr = 1'b0;
    m_hlen = 1'b0;
    m_vlen = 1'b0;
    tick(2);
  endtask

  // mode 0: zeros, 1: single F at line 5 shift 10, 2: double line pulses,
  // 3: line 2 has 81 shifts, 4: address-derived pattern
  task automatic run_frame(input int nlines, input int mode);
    for (int l = 0; l < nlines; l++) begin
      int nsh;
      nsh = (mode == 3 && l == 2) ? HS + 1 : HS;
      for (int s = 0; s < nsh; s++) begin
        logic [3:0] d;
        case (mode)
          1:       d = (l == 5 && s == 10) ? 4'hF : 4'h0;
          4:       d = 4'((s + 3 * l) & 15);
          default: d = 4'h0;
        endcase
        do_shift(d);
      end
      do_line();
      if (mode == 2) do_line();
    end
  endtask

  task automatic chk_flags(input string tag);
    tick(4);
    chk({tag, "_err_hlen"}, 32'(err_hlen), 32'(m_hlen));
    chk({tag, "_err_vlen"}, 32'(err_vlen), 32'(m_vlen));
  endtask

  // Every pixel strobe and frame strobe is matched against the model, in order.
  always @(negedge clk) begin
    if (rst_x) begin
      if (pix_vld) begin
        if (pq.size() == 0) begin
          chk("pix_unexpected", 32'(pix_vld), 32'd0);
        end else begin
          pix_t e;
          e = pq.pop_front();
          chk("pix_x", 32'(pix_x), 32'(e.x));
          chk("pix_y", 32'(pix_y), 32'(e.y));
          chk("pix_dat", 32'(pix_dat), 32'(e.d));
        end
        if (pix_dat == 4'hF && !f_seen) begin
          f_seen = 1'b1;
          f_x = pix_x;
          f_y = pix_y;
        end
      end
      if (frame_done) begin
        if (fq.size() == 0) begin
          chk("frame_done_unexpected", 32'(frame_done), 32'd0);
        end else begin
          frm_t e;
          e = fq.pop_front();
          chk("frame_sum", 32'(frame_sum), 32'(e.sum));
          chk("frame_lines", 32'(frame_lines), 32'(e.lines));
        end
      end
    end
  end

  initial begin
    tick(3);
    chk("rst_pix_vld", 32'(pix_vld), 32'd0);
    chk("rst_frame_sum", 32'(frame_sum), 32'd0);
    chk("rst_frame_lines", 32'(frame_lines), 32'd0);
    chk("rst_errs", 32'({err_hlen, err_vlen}), 32'd0);
    rst_x = 1'b1;
    tick(2);
    enable = 1'b1;
    m_en = 1'b1;
    tick(2);

    // Nominal: first frame pulse only arms the receiver, then two zero frames.
    do_frame();
    run_frame(V_LINES, 0);
    do_frame();
    run_frame(V_LINES, 0);
    do_frame();
    chk_flags("nominal");
    chk("nominal_sum_lit", 32'(frame_sum), 32'h0000);
    chk("nominal_lines_lit", 32'(frame_lines), 32'(V_LINES));

    // Single bright nibble at line 5, shift 10.
    run_frame(V_LINES, 1);
    do_frame();
    chk_flags("single");
    chk("single_sum_lit", 32'(frame_sum), 32'h01E0);
    chk("single_seen", 32'(f_seen), 32'd1);
    chk("single_x_lit", 32'(f_x), 32'd40);
    chk("single_y_lit", 32'(f_y), 32'd5);

    // Double line pulses: second pulse ignored.
    run_frame(V_LINES, 2);
    do_frame();
    chk_flags("dbl_line");
    chk("dbl_line_lines_lit", 32'(frame_lines), 32'(V_LINES));
    chk("dbl_line_hlen_lit", 32'(err_hlen), 32'd0);

    // Over-long line.
    run_frame(V_LINES, 3);
    do_frame();
    chk_flags("long_line");
    chk("long_line_hlen_lit", 32'(err_hlen), 32'd1);
    do_err_clr();
    chk_flags("long_line_clr");

    // Short then tall frame.
    run_frame(V_LINES - 1, 0);
    do_frame();
    chk_flags("short_frame");
    chk("short_lines_lit", 32'(frame_lines), 32'(V_LINES - 1));
    chk("short_vlen_lit", 32'(err_vlen), 32'd1);
    do_err_clr();
    run_frame(V_LINES + 1, 0);
    do_frame();
    chk_flags("tall_frame");
    chk("tall_lines_lit", 32'(frame_lines), 32'(V_LINES + 1));

    // Patterned frame exercises the signature with varied data.
    do_err_clr();
    run_frame(V_LINES, 4);
    do_frame();
    chk_flags("pattern");

    // Reset mid-line, then enable toggled.
    run_frame(2, 4);
    for (int s = 0; s < 20; s++) do_shift(4'(s));
    tick(4);
    rst_x = 1'b0;
    tick(2);
    chk("midrst_pix_vld", 32'(pix_vld), 32'd0);
    chk("midrst_frame_done", 32'(frame_done), 32'd0);
    chk("midrst_frame_sum", 32'(frame_sum), 32'd0);
    chk("midrst_frame_lines", 32'(frame_lines), 32'd0);
    chk("midrst_errs", 32'({err_hlen, err_vlen}), 32'd0);
    rst_x = 1'b1;
    m_active = 1'b0;
    m_hlen = 1'b0;
    m_vlen = 1'b0;
    m_clear();
    pq.delete();
    fq.delete();
    tick(2);
    enable = 1'b0;
    m_en = 1'b0;
    m_active = 1'b0;
    m_clear();
    do_frame();
    do_shift(4'hA);
    do_shift(4'h5);
    do_line();
    enable = 1'b1;
    m_en = 1'b1;
    tick(2);
    do_frame();
    run_frame(V_LINES, 4);
    do_frame();
    chk_flags("recover");
    chk("recover_lines_lit", 32'(frame_lines), 32'(V_LINES));

    tick(6);
    chk("pix_queue_drained", 32'(pq.size()), 32'd0);
    chk("frame_queue_drained", 32'(fq.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
